// File: rtl/signed_mac_sequencer.sv
// Sequencer/accumulator for a multi-cycle signed multiplier: feeds operand pairs,
// accumulates sign-extended products and emits the dot product on a valid/ready port.
module signed_mac_sequencer #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_last,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_start,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic                 mul_ready,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic [CNT_WIDTH-1:0] acc_count,
  output logic                 acc_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUTPUT} state_t;

  state_t                state_q;
  logic                  in_ready_q;
  logic                  mul_start_q;
  logic                  acc_valid_q;
  logic                  acc_ovf_q;
  logic                  last_q;
  logic [WIDTH-1:0]      mul_a_q, mul_b_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic        [ACC_WIDTH-1:0] acc_d;
  logic        [CNT_WIDTH-1:0] cnt_d;
  logic                        ovf_d;

  // Signed overflow: addends share a sign that the wrapped sum does not.
  assign prod_ext = ACC_WIDTH'($signed(mul_product));
  assign acc_d    = acc_q + prod_ext;
  assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign ovf_d    = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (acc_d[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      mul_start_q <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_ovf_q   <= 1'b0;
      last_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            mul_a_q     <= in_a;
            mul_b_q     <= in_b;
            last_q      <= in_last;
            in_ready_q  <= 1'b0;
            mul_start_q <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          mul_start_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // mul_ready is only trusted here; the multiplier has no reset.
          if (mul_ready) begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            acc_ovf_q <= acc_ovf_q | ovf_d;
            if (last_q) begin
              acc_valid_q <= 1'b1;
              state_q     <= S_OUTPUT;
            end else begin
              in_ready_q  <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_OUTPUT: begin
          if (acc_ready) begin
            acc_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          mul_start_q <= 1'b0;
          acc_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_start = mul_start_q;
  assign acc_valid = acc_valid_q;
  assign acc_out   = acc_q;
  assign acc_count = cnt_q;
  assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_signed_mac_sequencer.sv
// Bench for signed_mac_sequencer: two instances (24- and 16-bit accumulators) share
// stimulus, each paired with a behavioural multiplier; sums checked against an integer model.
module tb_signed_mac_sequencer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, acc_ready;
  logic [W-1:0] in_a, in_b;

  logic         rdy [2];
  logic [W-1:0] ma [2], mb [2];
  logic         ms [2];
  logic [2*W-1:0] mp [2], pl [2];
  logic         mr [2];
  int           mcnt [2];
  logic         av [2], ovf [2];
  logic [7:0]   cnt [2];
  logic [23:0]  acc0;
  logic [15:0]  acc1;

  int cyc = 0;
  int total = 0, passed = 0, failed = 0;
  int acc_cyc = 0, prev_acc_cyc = 0, lat;
  int qa [$], qb [$];
  longint o_s24, o_s16;
  longint o_ovf16, o_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  signed_mac_sequencer #(.WIDTH(W)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mul_a(ma[0]), .mul_b(mb[0]), .mul_start(ms[0]), .mul_product(mp[0]),
    .mul_ready(mr[0]), .acc_valid(av[0]), .acc_ready(acc_ready), .acc_out(acc0),
    .acc_count(cnt[0]), .acc_ovf(ovf[0]));

  signed_mac_sequencer #(.WIDTH(W), .ACC_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mul_a(ma[1]), .mul_b(mb[1]), .mul_start(ms[1]), .mul_product(mp[1]),
    .mul_ready(mr[1]), .acc_valid(av[1]), .acc_ready(acc_ready), .acc_out(acc1),
    .acc_count(cnt[1]), .acc_ovf(ovf[1]));

  // Reset-less multiplier: ready drops at start, product appears W edges later.
  initial begin
    for (int i = 0; i < 2; i++) begin mr[i] = 1'bx; mp[i] = 'x; mcnt[i] = 0; end
  end
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ms[i]) begin
        mcnt[i] <= W;
        mr[i]   <= 1'b0;
        mp[i]   <= 'x;
        pl[i]   <= 16'(int'($signed(ma[i])) * int'($signed(mb[i])));
      end else if (mcnt[i] > 0) begin
        mcnt[i] <= mcnt[i] - 1;
        if (mcnt[i] == 1) begin mr[i] <= 1'b1; mp[i] <= pl[i]; end
      end
    end
  end

  task automatic chk(string tag, longint obs, longint exp);
    total++;
    assert (obs === exp) passed++;
    else begin failed++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end
  endtask

  function automatic longint wrapw(longint t, int aw);
    longint m = longint'(1) << aw;
    longint r = t % m;
    if (r < 0) r += m;
    if (r >= m/2) r -= m;
    return r;
  endfunction

  // Dot product of the queued pairs, wrapped to aw bits, with any-step overflow flag.
  task automatic model(input int aw, output longint s, output bit ov);
    longint t, lim = longint'(1) << (aw-1);
    s = 0; ov = 0;
    for (int i = 0; i < qa.size(); i++) begin
      t = s + longint'(qa[i]) * longint'(qb[i]);
      if (t >= lim || t < -lim) ov = 1;
      s = wrapw(t, aw);
    end
  endtask

  task automatic send(int a, int b, bit last);
    int n = 0;
    in_a = a[7:0]; in_b = b[7:0]; in_last = last; in_valid = 1'b1;
    while (!rdy[0] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("accept_timeout", 0, 1);
    prev_acc_cyc = acc_cyc; acc_cyc = cyc;
    qa.push_back(a); qb.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get(int hold, output int latency);
    int n = 0;
    longint s24, s16, hold_v;
    bit v24, v16;
    while (!av[0] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("sum_timeout", 0, 1);
    latency = cyc - acc_cyc;
    model(24, s24, v24);
    model(16, s16, v16);
    o_cnt = (qa.size() > 255) ? 255 : qa.size();
    o_s24 = $signed(acc0); o_s16 = $signed(acc1); o_ovf16 = ovf[1];
    chk("sum24", $signed(acc0), s24);
    chk("sum16", $signed(acc1), s16);
    chk("cnt24", cnt[0], o_cnt);
    chk("cnt16", cnt[1], o_cnt);
    chk("ovf24", ovf[0], v24);
    chk("ovf16", ovf[1], v16);
    chk("valid16", av[1], 1);
    hold_v = acc0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", av[0], 1);
      chk("hold_sum", acc0, hold_v);
      chk("hold_cnt", cnt[0], o_cnt);
      chk("hold_inrdy", rdy[0], 0);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk("clr_valid", av[0], 0);
    chk("clr_sum", acc0, 0);
    chk("clr_cnt", cnt[0], 0);
    chk("clr_ovf", ovf[0], 0);
    qa.delete(); qb.delete();
  endtask

  initial begin
    int np, a, b;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; acc_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_inrdy", rdy[0], 1);
    chk("rst_start", ms[0], 0);
    chk("rst_valid", av[0], 0);
    chk("rst_sum", acc0, 0);
    chk("rst_cnt", cnt[0], 0);
    chk("rst_ovf", ovf[0], 0);
    chk("rst_mula", ma[0], 0);
    chk("rst_mulb", mb[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Single pair: start pulse, held operands, latency W+3.
    send(3, -4, 1);
    chk("start_hi", ms[0], 1);
    chk("start_inrdy", rdy[0], 0);
    @(negedge clk);
    chk("start_lo", ms[0], 0);
    chk("hold_mula", ma[0], 3);
    chk("hold_mulb", mb[0], 8'hFC);
    get(0, lat);
    chk("lat_single", lat, W + 3);
    chk("single_sum", o_s24, -12);
    chk("single_cnt", o_cnt, 1);

    // Three-term dot product, one term per W+3 cycles.
    send(5, 6, 0);
    send(-7, 8, 0);
    chk("spacing1", acc_cyc - prev_acc_cyc, W + 3);
    send(-2, -9, 1);
    chk("spacing2", acc_cyc - prev_acc_cyc, W + 3);
    get(0, lat);
    chk("dot3_sum", o_s24, -8);
    chk("dot3_cnt", o_cnt, 3);

    // Extremes; immediate acc_ready gives next accept at W+4.
    send(-128, -128, 1);
    get(0, lat);
    chk("neg_neg", o_s24, 16384);
    send(-128, 127, 1);
    chk("spacing_out", acc_cyc - prev_acc_cyc, W + 4);
    get(0, lat);
    chk("neg_pos", o_s24, -16256);

    // 16-bit accumulator wraps.
    send(127, 127, 0);
    send(127, 127, 0);
    send(127, 127, 1);
    get(0, lat);
    chk("wrap16_sum", o_s16, -17149);
    chk("wrap16_ovf", o_ovf16, 1);
    chk("wrap24_sum", o_s24, 48387);

    // Consumer stall.
    send(1, 1, 1);
    get(20, lat);

    // Reset while the second term is in WAIT.
    send(4, 5, 0);
    send(6, 7, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wrst_inrdy", rdy[0], 1);
    chk("wrst_start", ms[0], 0);
    chk("wrst_valid", av[0], 0);
    chk("wrst_sum", acc0, 0);
    chk("wrst_cnt", cnt[0], 0);
    chk("wrst_mula", ma[0], 0);
    qa.delete(); qb.delete();
    send(2, 3, 1);
    get(0, lat);
    chk("post_rst_sum", o_s24, 6);
    chk("post_rst_cnt", o_cnt, 1);

    // Randomized dot products against the model.
    for (int k = 0; k < 8; k++) begin
      np = $urandom_range(1, 6);
      for (int j = 0; j < np; j++) begin
        a = int'($signed(8'($urandom)));
        b = int'($signed(8'($urandom)));
        send(a, b, j == np - 1);
      end
      get($urandom_range(0, 3), lat);
      chk("rand_lat", lat, W + 3);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
